serial_add_ctrl: RTL and testbench

//   Sequencer that reuses a single 1-bit full-adder cell to add two WIDTH-bit

---
 rtl/serial_add_ctrl_pkg.sv | 21 ++
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl_fulladd.sv | 11 +
 rtl/serial_add_ctrl.sv | 98 +++++++++
 tb/tb_serial_add_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

  // Sequencer states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Ceiling log2, used to size the bit counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side start/done handshake and result bus for serial_add_ctrl.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl_fulladd.sv
// The single 1-bit full-adder cell shared by every bit of the serial add.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);
  assign Sum   = a ^ b ^ Cin;
  assign Carry = (a & b) | (Cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, one bit per clk.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int              CW   = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] psum;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  logic             cell_sum, cell_carry;
  logic [WIDTH-1:0] psum_nx;

  fulladd u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .Cin   (carry_q),
    .Sum   (cell_sum),
    .Carry (cell_carry)
  );

  // New sum bit enters at the top; after WIDTH shifts this is the full result.
  assign psum_nx = {cell_sum, psum};

  // Sequencer: capture on start, shift WIDTH bits, publish result with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      psum    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE (back-to-back ops).
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            carry_q <= bus.cin;
            cnt     <= '0;
            state   <= SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          psum    <= psum_nx[WIDTH-1:1];
          carry_q <= cell_carry;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry_q here is the carry into the MSB.
            sum_q  <= psum_nx;
            cout_q <= cell_carry;
            ovf_q  <= carry_q ^ cell_carry;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full op: start in cycle 0, verify busy window, latency and result.
  task automatic run_op(input vec_t v, input logic [W-1:0] prev_sum);
    int n;
    bit seen;
    bit busy_bad;
    @(negedge clk);
    bus.start = 1'b1; bus.a = v.a; bus.b = v.b; bus.cin = v.cin;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~v.a; bus.b = ~v.b; bus.cin = ~v.cin;
    chk("sum_held_in_shift", {24'd0, bus.sum}, {24'd0, prev_sum});
    n = 1; seen = 0; busy_bad = 0;
    while (n < W + 6) begin
      if (bus.done) begin seen = 1; break; end
      if (!bus.busy) busy_bad = 1;
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", n, W + 1);
    chk("busy_in_shift", 32'(busy_bad), 32'd0);
    chk("busy_with_done", 32'(bus.busy), 32'd0);
    chk("sum", {24'd0, bus.sum}, {24'd0, v.sum});
    chk("cout", 32'(bus.cout), 32'(v.cout));
    chk("ovf", 32'(bus.ovf), 32'(v.ovf));
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ndone;
    int dc[2];
    logic [W-1:0] ds[2];
    logic [W-1:0] prev;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[7] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", {24'd0, bus.sum}, 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;

    prev = '0;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], prev);
      prev = vecs[i].sum;
    end

    // Reset in cycle 4 of an op aborts it; previous result (80/1/0) is wiped.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) ndone++;
      if (c == 1) bus.start = 1'b0;
      if (c == 4) begin
        chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        chk("rst_mid_sum_before", {24'd0, bus.sum}, 32'h80);
        rst = 1'b1;
      end
      if (c == 5) begin
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_sum", {24'd0, bus.sum}, 32'd0);
        chk("rst_mid_cout", 32'(bus.cout), 32'd0);
        chk("rst_mid_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
      end
    end
    chk("rst_mid_no_done", ndone, 0);

    // Start pulsed again in cycle 3 while busy: ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01; bus.cin = 1'b0;
    ndone = 0; dc[0] = 0; ds[0] = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) begin
        ndone++; dc[0] = c; ds[0] = bus.sum;
        chk("ign_cout", 32'(bus.cout), 32'd1);
      end
      if (c == 1) bus.start = 1'b0;
      if (c == 3) begin bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; end
      if (c == 4) bus.start = 1'b0;
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_done_cycle", dc[0], 9);
    chk("ign_sum", {24'd0, ds[0]}, 32'h00);

    // Start held high: second op accepted in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    ndone = 0; dc[0] = 0; dc[1] = 0; ds[0] = '0; ds[1] = '0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) begin
        if (ndone < 2) begin dc[ndone] = c; ds[ndone] = bus.sum; end
        ndone++;
      end
      if (bus.done && bus.busy) chk("b2b_busy_done_excl", 32'd1, 32'd0);
      if (c == 1) begin bus.a = 8'h03; bus.b = 8'h04; end
      if (c == 18) bus.start = 1'b0;
    end
    chk("b2b_done_count", ndone, 2);
    chk("b2b_done1_cycle", dc[0], 9);
    chk("b2b_sum1", {24'd0, ds[0]}, 32'h30);
    chk("b2b_done2_cycle", dc[1], 18);
    chk("b2b_sum2", {24'd0, ds[1]}, 32'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
